bluejay_line_sequencer: RTL

Downstream stage of the USB-to-Bluejay interface: consumes the 32-bit word stream and the line/frame-ready flags that interface produces, and paces it onto the Bluejay SLM data bus. It pops exactly one line of words per line-ready, frames each line with a sync pulse and blanking gap, and issues a frame-update pulse after the last line. It owns all Bluejay-side sequencing; the upstream interface only buffers and hands over words.

---
 rtl/bluejay_pkg.sv | 20 ++
 rtl/bluejay_output_stage.sv | 43 ++++
 rtl/bluejay_line_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bluejay_pkg.sv
// Shared types and default geometry for the Bluejay SLM line sequencer.
// BLUEJAY_INVERT_EN selects per-frame data inversion in the output stage.
package bluejay_pkg;

  localparam int WORD_W              = 32;
  localparam int DEF_WORDS_PER_LINE  = 40;
  localparam int DEF_LINES_PER_FRAME = 1280;
  localparam int DEF_LINE_GAP        = 4;

  typedef enum logic [2:0] {
    IDLE,
    LINE_WAIT,
    SYNC,
    READ,
    DRAIN,
    GAP,
    UPDATE
  } state_t;

endpackage

// File: rtl/bluejay_output_stage.sv
// Output register for the SLM data bus.
// BLUEJAY_INVERT_EN adds a frame-parity bit that inverts odd frames.
module bluejay_output_stage
  import bluejay_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
`ifdef BLUEJAY_INVERT_EN
  input  logic              toggle,
`endif
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] data,
  output logic              valid
);

  logic [WORD_W-1:0] word_d;

`ifdef BLUEJAY_INVERT_EN
  logic parity;

  // Odd frames carry inverted pixels for LC DC balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= parity ^ toggle;
  end

  assign word_d = parity ? ~word : word;
`else
  assign word_d = word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= load ? word_d : '0;
      valid <= load;
    end
  end

endmodule

// File: rtl/bluejay_line_sequencer.sv
// Paces upstream 32-bit words onto the Bluejay SLM bus, line by line.
// BLUEJAY_INVERT_EN enables per-frame data inversion.
module bluejay_line_sequencer
  import bluejay_pkg::*;
#(
  parameter  int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
  parameter  int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter  int LINE_GAP        = DEF_LINE_GAP,
  localparam int LW = $clog2(LINES_PER_FRAME)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              fifo_empty_i,
  input  logic              next_line_rdy_i,
  input  logic              next_frame_rdy_i,
  output logic              get_next_word_o,
  output logic [WORD_W-1:0] bluejay_data_o,
  output logic              bluejay_valid_o,
  output logic              bluejay_sync_o,
  output logic              bluejay_update_o,
  output logic [LW-1:0]     line_cnt_o,
  output logic              underflow_o
);

  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int GW = $clog2(LINE_GAP + 1);
  localparam logic [WW-1:0] W_LAST = WW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LINES_PER_FRAME - 1);
  localparam logic [GW-1:0] G_LAST = GW'(LINE_GAP - 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  state_t        state_q, state_d;
  logic [WW-1:0] word_q;
  logic [LW-1:0] line_q;
  logic [GW-1:0] gap_q;
  logic          pop, pop_q, gap_done;
  logic          sync_q, upd_q, under_q;

  // Async assert, synchronous release
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    gap_done = (state_q == GAP) && (gap_q == G_LAST);
    unique case (state_q)
      IDLE:      if (next_frame_rdy_i) state_d = SYNC;
      LINE_WAIT: if (next_line_rdy_i) state_d = SYNC;
      SYNC:      state_d = READ;
      READ: begin
        pop = !fifo_empty_i;
        if (pop && word_q == W_LAST) state_d = DRAIN;
      end
      DRAIN:     state_d = GAP;
      GAP: begin
        if (gap_done)
          state_d = (line_q == L_LAST) ? UPDATE : LINE_WAIT;
      end
      UPDATE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      gap_q  <= '0;
      line_q <= '0;
    end else begin
      if (pop)
        word_q <= (word_q == W_LAST) ? '0 : word_q + WW'(1);
      if (state_q == GAP && !gap_done)
        gap_q <= gap_q + GW'(1);
      else
        gap_q <= '0;
      if (state_q == IDLE && next_frame_rdy_i)
        line_q <= '0;
      else if (gap_done)
        line_q <= (line_q == L_LAST) ? '0 : line_q + LW'(1);
    end
  end

  // Strobes are registered so they line up with the data register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pop_q   <= 1'b0;
      sync_q  <= 1'b0;
      upd_q   <= 1'b0;
      under_q <= 1'b0;
    end else begin
      pop_q   <= pop;
      sync_q  <= (state_q == SYNC);
      upd_q   <= (state_q == UPDATE);
      under_q <= under_q | (state_q == READ && fifo_empty_i);
    end
  end

  bluejay_output_stage u_out (
    .clk    (clk_i),
    .rst_n  (rst_n),
    .load   (pop_q),
`ifdef BLUEJAY_INVERT_EN
    .toggle (state_q == UPDATE),
`endif
    .word   (data_i),
    .data   (bluejay_data_o),
    .valid  (bluejay_valid_o)
  );

  assign get_next_word_o  = pop;
  assign bluejay_sync_o   = sync_q;
  assign bluejay_update_o = upd_q;
  assign line_cnt_o       = line_q;
  assign underflow_o      = under_q;

endmodule
